// File: rtl/stopwatch_counter_core.sv
// Multi-digit stopwatch counter: per-digit modulus (radix or MM:SS), up/down,
// run/stop, load with clamping, clear, and lap freeze of the displayed value.
module stopwatch_counter_core #(
  parameter int unsigned c_DIGITS    = 4,
  parameter int unsigned c_RADIX     = 10,
  parameter int unsigned c_TIME_MODE = 0,
  parameter int unsigned c_WRAP      = 1
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_TICK,
  input  logic                  i_START_STOP,
  input  logic                  i_CLEAR,
  input  logic                  i_DIR,
  input  logic                  i_LOAD,
  input  logic [4*c_DIGITS-1:0] i_LOAD_VAL,
  input  logic                  i_LAP,
  output logic [4*c_DIGITS-1:0] o_COUNT,
  output logic [4*c_DIGITS-1:0] o_DISP,
  output logic                  o_RUNNING,
  output logic                  o_LAPPED,
  output logic                  o_TC
);

  localparam int unsigned W = 4 * c_DIGITS;

  function automatic logic [3:0] dig_max(int unsigned idx);
    if (c_TIME_MODE != 0) return ((idx % 2) == 1) ? 4'd5 : 4'd9;
    return (c_RADIX == 16) ? 4'hF : 4'd9;
  endfunction

  logic [W-1:0] count_q, snap_q;
  logic         run_q, lap_q, tc_q;

  logic [W-1:0] max_val, inc_val, dec_val, load_val;
  logic [W-1:0] count_d;
  logic         run_d, tc_d;
  logic         carry, borrow, at_term, step;

  always_comb begin
    max_val  = '0;
    inc_val  = count_q;
    dec_val  = count_q;
    load_val = i_LOAD_VAL;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int unsigned i = 0; i < c_DIGITS; i++) begin
      max_val[4*i +: 4] = dig_max(i);
      if (i_LOAD_VAL[4*i +: 4] > dig_max(i)) load_val[4*i +: 4] = dig_max(i);
      if (carry) begin
        if (count_q[4*i +: 4] == dig_max(i)) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = dig_max(i);
        end else begin
          dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow            = 1'b0;
        end
      end
    end
  end

  assign at_term = i_DIR ? (count_q == max_val) : (count_q == '0);
  // Step uses the run state before any same-cycle start/stop toggle.
  assign step    = run_q & i_TICK & ~i_CLEAR & ~i_LOAD;

  always_comb begin
    count_d = count_q;
    run_d   = run_q ^ i_START_STOP;
    tc_d    = 1'b0;
    if (i_CLEAR) begin
      count_d = '0;
      run_d   = 1'b0;
    end else if (i_LOAD) begin
      count_d = load_val;
    end else if (step) begin
      if (at_term) begin
        tc_d = 1'b1;
        if (c_WRAP != 0) count_d = i_DIR ? inc_val : dec_val;
        else             run_d   = 1'b0;
      end else begin
        count_d = i_DIR ? inc_val : dec_val;
      end
    end
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      count_q <= '0;
      snap_q  <= '0;
      run_q   <= 1'b0;
      lap_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
      tc_q    <= tc_d;
      if (i_CLEAR) begin
        lap_q <= 1'b0;
      end else if (i_LAP) begin
        if (!lap_q) begin
          snap_q <= count_q;
          lap_q  <= 1'b1;
        end else begin
          lap_q  <= 1'b0;
        end
      end
    end
  end

  assign o_COUNT   = count_q;
  assign o_DISP    = lap_q ? snap_q : count_q;
  assign o_RUNNING = run_q;
  assign o_LAPPED  = lap_q;
  assign o_TC      = tc_q;

endmodule

// File: tb/tb_stopwatch_counter_core.sv
// Bench for stopwatch_counter_core: four parameterisations share one stimulus
// stream and are checked every cycle against an integer-valued model.
module tb_stopwatch_counter_core;

  logic        clk, rst_n, tick, ss, clr, dir, ld, lap;
  logic [15:0] lv;

  logic [15:0] cnt  [4];
  logic [15:0] disp [4];
  logic        runo [4];
  logic        lapo [4];
  logic        tco  [4];

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance configs: 0 default, 1 MM:SS, 2 saturating, 3 hex
  int cfg_radix [4] = '{10, 10, 10, 16};
  int cfg_time  [4] = '{0, 1, 0, 0};
  int cfg_wrap  [4] = '{1, 1, 0, 1};

  int m_val [4];
  int m_snap[4];
  bit m_run [4];
  bit m_lap [4];
  bit m_tc  [4];

  stopwatch_counter_core #(.c_DIGITS(4), .c_RADIX(10), .c_TIME_MODE(0), .c_WRAP(1)) u0 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_TICK(tick), .i_START_STOP(ss), .i_CLEAR(clr),
    .i_DIR(dir), .i_LOAD(ld), .i_LOAD_VAL(lv), .i_LAP(lap),
    .o_COUNT(cnt[0]), .o_DISP(disp[0]), .o_RUNNING(runo[0]), .o_LAPPED(lapo[0]), .o_TC(tco[0]));
  stopwatch_counter_core #(.c_DIGITS(4), .c_RADIX(10), .c_TIME_MODE(1), .c_WRAP(1)) u1 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_TICK(tick), .i_START_STOP(ss), .i_CLEAR(clr),
    .i_DIR(dir), .i_LOAD(ld), .i_LOAD_VAL(lv), .i_LAP(lap),
    .o_COUNT(cnt[1]), .o_DISP(disp[1]), .o_RUNNING(runo[1]), .o_LAPPED(lapo[1]), .o_TC(tco[1]));
  stopwatch_counter_core #(.c_DIGITS(4), .c_RADIX(10), .c_TIME_MODE(0), .c_WRAP(0)) u2 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_TICK(tick), .i_START_STOP(ss), .i_CLEAR(clr),
    .i_DIR(dir), .i_LOAD(ld), .i_LOAD_VAL(lv), .i_LAP(lap),
    .o_COUNT(cnt[2]), .o_DISP(disp[2]), .o_RUNNING(runo[2]), .o_LAPPED(lapo[2]), .o_TC(tco[2]));
  stopwatch_counter_core #(.c_DIGITS(4), .c_RADIX(16), .c_TIME_MODE(0), .c_WRAP(1)) u3 (
    .i_CLK(clk), .i_RST_N(rst_n), .i_TICK(tick), .i_START_STOP(ss), .i_CLEAR(clr),
    .i_DIR(dir), .i_LOAD(ld), .i_LOAD_VAL(lv), .i_LAP(lap),
    .o_COUNT(cnt[3]), .o_DISP(disp[3]), .o_RUNNING(runo[3]), .o_LAPPED(lapo[3]), .o_TC(tco[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int modu(int k, int i);
    if (cfg_time[k] != 0) return (i % 2 == 1) ? 6 : 10;
    return cfg_radix[k];
  endfunction

  function automatic int total(int k);
    int t = 1;
    for (int i = 0; i < 4; i++) t = t * modu(k, i);
    return t;
  endfunction

  // Mixed-radix digits -> integer, clamping out-of-range digits
  function automatic int to_int(int k, logic [15:0] b);
    int v = 0;
    int w = 1;
    int d, m;
    for (int i = 0; i < 4; i++) begin
      m = modu(k, i);
      d = int'(b[4*i +: 4]);
      if (d > m - 1) d = m - 1;
      v = v + d * w;
      w = w * m;
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bits(int k, int v);
    logic [15:0] r = '0;
    int m;
    for (int i = 0; i < 4; i++) begin
      m = modu(k, i);
      r[4*i +: 4] = 4'(v % m);
      v = v / m;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_val[k] = 0; m_snap[k] = 0; m_run[k] = 0; m_lap[k] = 0; m_tc[k] = 0;
    end
  endtask

  task automatic model_update();
    bit nrun;
    int top;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 4; k++) begin
      top     = total(k) - 1;
      m_tc[k] = 0;
      if (clr) m_lap[k] = 0;
      else if (lap) begin
        if (!m_lap[k]) begin m_snap[k] = m_val[k]; m_lap[k] = 1; end
        else m_lap[k] = 0;
      end
      nrun = m_run[k] ^ ss;
      if (clr) begin
        m_val[k] = 0; nrun = 0;
      end else if (ld) begin
        m_val[k] = to_int(k, lv);
      end else if (m_run[k] && tick) begin
        if ((dir && m_val[k] == top) || (!dir && m_val[k] == 0)) begin
          m_tc[k] = 1;
          if (cfg_wrap[k] != 0) m_val[k] = dir ? 0 : top;
          else nrun = 0;
        end else begin
          m_val[k] = dir ? m_val[k] + 1 : m_val[k] - 1;
        end
      end
      m_run[k] = nrun;
    end
  endtask

  task automatic cmp(string name, int k, logic [15:0] act, logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[u%0d] @%0t: got %h expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic check_all();
    logic [15:0] ec;
    for (int k = 0; k < 4; k++) begin
      ec = to_bits(k, m_val[k]);
      cmp("count",   k, cnt[k], ec);
      cmp("disp",    k, disp[k], m_lap[k] ? to_bits(k, m_snap[k]) : ec);
      cmp("running", k, {15'd0, runo[k]}, {15'd0, m_run[k]});
      cmp("lapped",  k, {15'd0, lapo[k]}, {15'd0, m_lap[k]});
      cmp("tc",      k, {15'd0, tco[k]},  {15'd0, m_tc[k]});
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_update();
    #1;
    check_all();
    ss = 0; lap = 0; clr = 0; ld = 0; tick = 0;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) begin
      tick = 1;
      run_cycle();
    end
  endtask

  initial begin
    rst_n = 0; tick = 0; ss = 0; clr = 0; dir = 1; ld = 0; lap = 0; lv = '0;
    model_reset();
    #2;
    check_all();
    cmp("lit_reset_count", 0, cnt[0], 16'h0000);
    run_cycle();
    @(negedge clk);
    rst_n = 1;

    // Decimal rollover
    ss = 1; run_cycle();
    ticks(9999);
    cmp("lit_9999", 0, cnt[0], 16'h9999);
    ticks(1);
    cmp("lit_wrap_zero", 0, cnt[0], 16'h0000);
    cmp("lit_wrap_tc",   0, {15'd0, tco[0]}, 16'd1);
    run_cycle();
    cmp("lit_tc_one_cycle", 0, {15'd0, tco[0]}, 16'd0);

    // MM:SS moduli and load clamping
    clr = 1; run_cycle();
    ld = 1; lv = 16'h0959; ss = 1; run_cycle();
    ticks(1);
    cmp("lit_tm_1000", 1, cnt[1], 16'h1000);
    ld = 1; lv = 16'h5959; run_cycle();
    ticks(1);
    cmp("lit_tm_wrap", 1, cnt[1], 16'h0000);
    cmp("lit_tm_tc",   1, {15'd0, tco[1]}, 16'd1);
    ld = 1; lv = 16'h7A9F; run_cycle();
    cmp("lit_tm_clamp", 1, cnt[1], 16'h5959);
    cmp("lit_dec_clamp", 0, cnt[0], 16'h7999);

    // Saturating down-count
    clr = 1; run_cycle();
    dir = 0;
    ld = 1; lv = 16'h0002; ss = 1; run_cycle();
    ticks(1);
    cmp("lit_sat_1", 2, cnt[2], 16'h0001);
    ticks(1);
    cmp("lit_sat_0", 2, cnt[2], 16'h0000);
    cmp("lit_sat_no_tc", 2, {15'd0, tco[2]}, 16'd0);
    ticks(1);
    cmp("lit_sat_hold", 2, cnt[2], 16'h0000);
    cmp("lit_sat_tc",   2, {15'd0, tco[2]}, 16'd1);
    cmp("lit_sat_stop", 2, {15'd0, runo[2]}, 16'd0);
    ticks(1);
    cmp("lit_sat_still", 2, cnt[2], 16'h0000);
    cmp("lit_sat_tc_gone", 2, {15'd0, tco[2]}, 16'd0);
    ss = 1; run_cycle();
    cmp("lit_restart_no_tc", 2, {15'd0, tco[2]}, 16'd0);
    ticks(1);
    cmp("lit_restart_tc",   2, {15'd0, tco[2]}, 16'd1);
    cmp("lit_restart_stop", 2, {15'd0, runo[2]}, 16'd0);

    // Lap freeze
    clr = 1; run_cycle();
    dir = 1;
    ss = 1; run_cycle();
    ticks(12);
    cmp("lit_lap_pre", 0, cnt[0], 16'h0012);
    lap = 1; run_cycle();
    ticks(5);
    cmp("lit_lap_disp",  0, disp[0], 16'h0012);
    cmp("lit_lap_count", 0, cnt[0],  16'h0017);
    lap = 1; run_cycle();
    cmp("lit_lap_release", 0, disp[0], 16'h0017);

    // Same-cycle events
    clr = 1; run_cycle();
    ss = 1; tick = 1; run_cycle();
    cmp("lit_ss_tick_count", 0, cnt[0], 16'h0000);
    cmp("lit_ss_tick_run",   0, {15'd0, runo[0]}, 16'd1);
    clr = 1; ld = 1; lv = 16'h1234; tick = 1; run_cycle();
    cmp("lit_clr_ld_count", 0, cnt[0], 16'h0000);
    cmp("lit_clr_ld_run",   0, {15'd0, runo[0]}, 16'd0);
    ss = 1; lap = 1; ticks(2);
    ld = 1; lv = 16'h0003; ss = 1; run_cycle();
    clr = 1; lap = 1; ss = 1; run_cycle();
    cmp("lit_clr_lap", 0, {15'd0, lapo[0]}, 16'd0);

    // Asynchronous reset mid-count while lapped
    ss = 1; run_cycle();
    ticks(3);
    lap = 1; run_cycle();
    ticks(2);
    cmp("lit_pre_rst_lapped", 0, {15'd0, lapo[0]}, 16'd1);
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    cmp("lit_rst_disp", 0, disp[0], 16'h0000);
    @(negedge clk);
    rst_n = 1;

    // Hex carry
    ld = 1; lv = 16'h00FF; ss = 1; run_cycle();
    ticks(1);
    cmp("lit_hex_carry", 3, cnt[3], 16'h0100);
    ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
